// File: rtl/mem_port_responder.sv
// Memory-side responder: DEPTH x 16-bit array behind a valid/ready request/response port.
// Optional `define MEM_ERR_EN flags out-of-range addresses instead of wrapping them.
module mem_port_responder #(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [15:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EXEC = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t              state_r;
   logic [3:0]          wait_cnt_r;
   logic                write_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [15:0]         wdata_r;
   logic                req_ready_r;
   logic                resp_valid_r;
   logic [15:0]         resp_rdata_r;
   logic                resp_err_r;
   logic [15:0]         mem_r [DEPTH];

   logic [ADDR_W:0]     addr_ext_s;
   logic [IDX_W-1:0]    idx_s;
   logic                addr_oor_s;
   logic                mem_we_s;

   // Address decode of the latched request: modulo index and range flag
   always_comb begin
      addr_ext_s = {1'b0, addr_r};
      idx_s      = IDX_W'(addr_ext_s % (ADDR_W+1)'(DEPTH));
`ifdef MEM_ERR_EN
      addr_oor_s = (addr_ext_s >= (ADDR_W+1)'(DEPTH));
`else
      addr_oor_s = 1'b0;
`endif
      // A reset landing on the EXEC edge also cancels the store
      if (reset && (state_r == ST_EXEC) && write_r && !addr_oor_s) begin
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Request/response sequencing with registered handshake outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         wait_cnt_r   <= 4'd0;
         write_r      <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= 16'h0000;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 16'h0000;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  write_r     <= req_write;
                  addr_r      <= req_addr;
                  wdata_r     <= req_wdata;
                  wait_cnt_r  <= 4'(WAIT_CYCLES);
                  req_ready_r <= 1'b0;
                  resp_err_r  <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state_r <= ST_EXEC;
                  end else begin
                     state_r <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               wait_cnt_r <= wait_cnt_r - 4'd1;
               if (wait_cnt_r <= 4'd1) begin
                  state_r <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_valid_r <= 1'b1;
               state_r      <= ST_RESP;
               if (addr_oor_s) begin
                  resp_rdata_r <= 16'h0000;
                  resp_err_r   <= 1'b1;
               end else if (write_r) begin
                  resp_rdata_r <= wdata_r;
               end else begin
                  resp_rdata_r <= mem_r[idx_s];
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= 1'b1;
                  state_r      <= ST_IDLE;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Data array has no reset so its contents survive a reset pulse
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[idx_s] <= wdata_r;
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

endmodule
